// File: rtl/mult_accum.sv
// mult_accum: sums N_TERMS unsigned products from the upstream multiplier into
// one frame result. The result is held on a valid/ready output until it is
// consumed.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready product handshake (in_ready decoded from state only)
//   product [2*DW]    unsigned product, zero-extended into the accumulator
//   flush             synchronous discard of a partial frame (ignored in HOLD)
//   out_valid/out_ready result handshake (out_valid decoded from state only)
//   out_sum [AW]      completed frame sum, stable while out_valid is high
//   frames_done [8]   results consumed, wraps modulo 256
//
// state | meaning
// ------+--------------------------------------------------------------
// ACC   | accepting products, in_ready=1, out_valid=0
// HOLD  | frame result presented, in_ready=0, out_valid=1
module mult_accum #(
  parameter int DW      = 1,
  parameter int N_TERMS = 4,
  parameter int AW      = 2*DW + $clog2(N_TERMS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*DW-1:0] product,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [7:0]    frames_done
);

  localparam int CW = $clog2(N_TERMS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    frames_q, frames_d;
  logic [AW-1:0] acc_plus;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ACC;
      acc_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
    end
  end

  always_comb begin
    acc_plus = acc_q + AW'(product);
    state_d  = state_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    if (state_q == ST_ACC) begin
      // flush takes priority; a coincident product is consumed and dropped
      if (flush) begin
        acc_d = '0;
        cnt_d = '0;
      end else if (in_valid) begin
        if (cnt_q == LAST_CNT) begin
          sum_d   = acc_plus;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          acc_d = acc_plus;
          cnt_d = cnt_q + CW'(1);
        end
      end
    end else begin
      if (out_ready) begin
        frames_d = frames_q + 8'd1;
        state_d  = ST_ACC;
      end
    end
  end

  assign in_ready    = (state_q == ST_ACC);
  assign out_valid   = (state_q == ST_HOLD);
  assign out_sum     = sum_q;
  assign frames_done = frames_q;

endmodule

// File: tb/tb_mult_accum.sv
module tb_mult_accum;

  localparam int DW = 4;
  localparam int N  = 4;
  localparam int AW = 2*DW + $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2*DW-1:0] product;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [7:0]    frames_done;

  mult_accum #(.DW(DW), .N_TERMS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .product    (product),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model: frame contents as a list, completed sums as a queue
  int unsigned exp_q[$];
  int unsigned partial[$];
  bit          hold_m   = 1'b0;
  int          consumed = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // one clock cycle: check handshake outputs, drive inputs, advance the model
  task automatic cycle(input bit v, input int p, input bit f, input bit ordy);
    @(posedge clk);
    #2;
    chk("in_ready", longint'(in_ready), longint'(!hold_m));
    chk("out_valid", longint'(out_valid), longint'(hold_m));
    in_valid  = v;
    product   = p[2*DW-1:0];
    flush     = f;
    out_ready = ordy;
    if (!hold_m) begin
      if (f) begin
        partial.delete();
      end else if (v) begin
        partial.push_back(p);
        if (partial.size() == N) begin
          int unsigned s = 0;
          foreach (partial[i]) s += partial[i];
          exp_q.push_back(s);
          partial.delete();
          hold_m = 1'b1;
        end
      end
    end else if (ordy) begin
      hold_m = 1'b0;
    end
  endtask

  // asynchronous reset between edges; outputs checked before any edge occurs
  task automatic reset_mid();
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    product   = '0;
    rst       = 1'b1;
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_sum", longint'(out_sum), 0);
    chk("rst_frames_done", longint'(frames_done), 0);
    exp_q.delete();
    partial.delete();
    hold_m   = 1'b0;
    consumed = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // monitor: compares presented results against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      chk("frames_done", longint'(frames_done), longint'(consumed % 256));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_sum_unexpected actual=%0d required=none", out_sum);
        end else begin
          chk("out_sum", longint'(out_sum), longint'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            consumed++;
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    product   = '0;
    #1;
    chk("init_in_ready", longint'(in_ready), 1);
    chk("init_out_sum", longint'(out_sum), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // basic frame 1,0,1,1
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    chk("basic_sum", longint'(out_sum), 3);
    chk("basic_frames_pre", longint'(frames_done), 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("basic_frames_post", longint'(frames_done), 1);

    // max values, with 5 cycles of backpressure while in_valid is high
    for (int i = 0; i < 4; i++) cycle(1, 225, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 225, 0, 0);
    chk("max_sum", longint'(out_sum), 900);
    cycle(1, 225, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 7, 0, 0);
    cycle(0, 0, 0, 0);
    chk("after_bp_sum", longint'(out_sum), 28);
    cycle(0, 0, 0, 1);

    // flush mid-frame, then flush while holding
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
    cycle(0, 0, 1, 0);
    chk("flush_sum", longint'(out_sum), 4);
    cycle(1, 1, 1, 0);
    chk("flush_hold_sum", longint'(out_sum), 4);
    cycle(0, 0, 0, 1);

    // reset mid-frame and in HOLD
    cycle(1, 9, 0, 0);
    cycle(1, 9, 0, 0);
    reset_mid();
    for (int i = 0; i < 4; i++) cycle(1, 2, 0, 0);
    reset_mid();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);

    // frames_done wrap
    for (int fr = 0; fr < 256; fr++) begin
      for (int i = 0; i < 4; i++)
        cycle(1, int'($urandom_range(0, 15) * $urandom_range(0, 15)), 0, 1);
      cycle(0, 0, 0, 1);
    end
    cycle(0, 0, 0, 0);
    chk("wrap_256", longint'(frames_done), 0);
    for (int i = 0; i < 4; i++) cycle(1, 3, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("wrap_257", longint'(frames_done), 1);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      cycle($urandom_range(0, 3) != 0,
            int'($urandom_range(0, 15) * $urandom_range(0, 15)),
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0);
    end

    // drain
    for (int c = 0; c < 4; c++) cycle(0, 0, 0, 1);
    @(negedge clk);
    chk("drain_empty", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_accum.md
# mult_accum

Accumulator stage directly downstream of `mult_1`. It consumes the registered `2*DW`-bit products over a valid/ready handshake and sums a fixed number of them (`N_TERMS`) into a frame result wide enough that it can never overflow. It presents each frame result on a held valid/ready output. Together with `mult_1` it forms the multiply-accumulate path used for small dot products.

## Interface
- `DW`, default 1: operand width of the upstream multiplier; the product is `2*DW` bits.
- `N_TERMS`, default 4: products per frame, ≥1.
- `AW`, default `2*DW + $clog2(N_TERMS)`: width of the accumulator and result (derived; do not override).

- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `product` is valid this cycle.
- `in_ready`  out  1: block accepts a product this cycle.
- `product`  in  `2*DW`: unsigned product from `mult_1` `output_value`.
- `flush`  in  1: synchronous discard of a partial frame.
- `out_valid`  out  1: `out_sum` holds a completed frame result.
- `out_ready`  in  1: downstream consumes the result.
- `out_sum`  out  `AW`: unsigned sum of `N_TERMS` products.
- `frames_done`  out  8: count of results consumed; wraps from 255 to 0.

## Operation
- Two states:
  - **ACC**: `in_ready`=1, `out_valid`=0.
  - **HOLD**: `in_ready`=0, `out_valid`=1.
- Internal registers: `acc` [AW], `cnt` [$clog2(N_TERMS)+1].
- **ACC, accept** (`in_valid & in_ready & !flush`):
  - If `cnt < N_TERMS-1`: `acc <= acc + product`, `cnt <= cnt+1`.
  - If `cnt == N_TERMS-1`: `out_sum <= acc + product`, `acc <= 0`, `cnt <= 0`, go to HOLD.
- **ACC, flush**: `acc <= 0`, `cnt <= 0`. Flush wins over a simultaneous `in_valid`; that product is dropped and counts as accepted, since `in_ready`=1.
- **HOLD**: `out_sum` is stable until the handshake completes. On `out_ready`: `frames_done <= frames_done+1` (mod 256), go to ACC. `flush` is ignored in HOLD, so a completed result is never lost.
- **Widths**: all arithmetic is unsigned. `product` is zero-extended to AW. Max sum `N_TERMS*(2^DW-1)^2 < 2^AW`, so no saturation or overflow logic is needed.
- **N_TERMS=1**: every accepted product goes straight to HOLD with `out_sum` = product.
- **`in_valid` in HOLD**: the upstream must hold the product; nothing is sampled.

## Timing
- **Reset** (async assert, sync deassert handled upstream). Outputs: `in_ready`=1, `out_valid`=0, `out_sum`=0, `frames_done`=0. Internal: `acc`=0, `cnt`=0, state ACC.
- **Reset mid-frame or in HOLD**: partial sum and pending result are discarded immediately; no `out_valid` pulse.
- **Latency**: last product accepted on edge k, so `out_valid`=1 and `out_sum` are valid in the cycle after edge k.
- **Throughput**: N_TERMS accept cycles plus ≥1 HOLD cycle per frame. `in_ready` is low for exactly one cycle when `out_ready` is tied high.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from any input.
- `mult_1` output registered at edge t is presented to this block as `product` in cycle t+1. The driving handshake wrapper owns `in_valid` alignment.

## Test plan
- **Reset**: `rst`=1 mid-run, then release → `out_valid`=0, `in_ready`=1, `out_sum`=0, `frames_done`=0 without any clock edge during reset.
- **Basic frame**: DW=1, N_TERMS=4, products 1,0,1,1 on consecutive cycles with `out_ready`=1 → `out_sum`=3, `out_valid` high for one cycle after the 4th accept, then `frames_done`=1.
- **Max values**: DW=4, N_TERMS=4, products 225×4 → `out_sum`=900 (AW=10); no overflow.
- **Backpressure**: `out_ready`=0 for 5 cycles in HOLD while `in_valid`=1 → `in_ready`=0, `out_sum` stable; after `out_ready`=1, the next frame starts from `acc`=0.
- **Flush**: 2 products (1,1), then `flush` with `in_valid`=1 and product 1, then 4 products of 1 → first result is 4. Flush asserted during HOLD → result still delivered.
- **Wrap**: 256 consumed frames → `frames_done` returns to 0; the 257th frame gives `frames_done`=1.
